bird_position: RTL

BIRD_POSITION -- requirements
Module: bird_position

---
 rtl/bird_position.sv | 104 ++++++++++
 1 files changed

// File: rtl/bird_position.sv
// Bird row tracker for the flappy-bird LED column: IDLE/FLY/CRASH control plus
// bounded position update. Build option: CEILING_CRASH_EN makes overshooting the top row a crash.
`timescale 1ns/1ps

module bird_position #(
  parameter int START_ROW = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  velocity,
  input  logic        tick,
  input  logic        start,
  output logic [3:0]  pos,
  output logic [15:0] row_onehot,
  output logic        playing,
  output logic        crashed,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLY   = 2'd1,
    S_CRASH = 2'd2
  } state_t;

  localparam logic [3:0] START_POS = START_ROW[3:0];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_pos;
  logic [3:0]         w_pos_nxt;
  logic [2:0]         w_vel_eff;
  logic signed [5:0]  w_sum;
  logic               w_floor_hit;
  logic               w_ceil_hit;

  // -4 is outside the kinematics range and is treated as no motion.
  assign w_vel_eff   = (velocity == 3'b100) ? 3'b000 : velocity;
  assign w_sum       = $signed({2'b00, r_pos}) + $signed({{3{w_vel_eff[2]}}, w_vel_eff});
  assign w_floor_hit = (w_sum < 6'sd0);
  assign w_ceil_hit  = (w_sum > 6'sd15);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pos   <= START_POS;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // Next-state and next-position logic
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    case (r_state)
      S_IDLE: begin
        w_pos_nxt = START_POS;
        if (start) begin
          w_state_nxt = S_FLY;
        end
      end
      S_FLY: begin
        if (tick) begin
          if (w_floor_hit) begin
            w_pos_nxt   = 4'd0;
            w_state_nxt = S_CRASH;
          end else if (w_ceil_hit) begin
            w_pos_nxt   = 4'd15;
`ifdef CEILING_CRASH_EN
            w_state_nxt = S_CRASH;
`else
            w_state_nxt = S_FLY;
`endif
          end else begin
            w_pos_nxt = w_sum[3:0];
          end
        end
      end
      S_CRASH: begin
        if (start) begin
          w_state_nxt = S_IDLE;
          w_pos_nxt   = START_POS;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pos_nxt   = START_POS;
      end
    endcase
  end

  // Outputs depend only on registered state and position
  always_comb begin
    pos         = r_pos;
    row_onehot  = 16'd1 << r_pos;
    playing     = (r_state == S_FLY);
    crashed     = (r_state == S_CRASH);
    o_dbg_state = r_state;
  end

endmodule
